btn_debounce: RTL and testbench

Front-end conditioner for the four board pushbuttons: synchronizes each raw button to the system clock, debounces it, and produces clean levels plus single-cycle press/release pulses. Its `btn_level[3:0]` output drives the `a`/`b`/`c`/`d` inputs of the downstream priority selector: bit 0 goes to `a`, bit 3 goes to `d`. The block produces the button interface that the selector consumes.

---
 rtl/btn_debounce.sv | 167 ++++++++++++++++
 tb/tb_btn_debounce.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: four-channel pushbutton conditioner.
// Each raw button passes through a two-flop synchronizer and a debounce FSM.
// The FSM emits a clean level plus one-cycle press and release pulses.
// Optional build macro: BTN_DEB_REPEAT_EN adds auto-repeat press pulses
// while a button is held.
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_UP     | level 0, waiting for the synchronized input to go high
// S_UP_CHK | input high, counting stable cycles toward a press
// S_DOWN   | level 1, waiting for the synchronized input to go low
// S_DOWN_CHK | input low, counting stable cycles toward a release
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_press,
    output logic [3:0] btn_release
);

    typedef enum logic [1:0] {
        S_UP       = 2'd0,
        S_UP_CHK   = 2'd1,
        S_DOWN     = 2'd2,
        S_DOWN_CHK = 2'd3
    } state_t;

    // Terminal count is compared before the increment, so the counter never wraps.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_DEB_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX) + 1;
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);
`else
    // Repeat timing parameters have no effect in this build.
    logic w_unused_rpt;
    assign w_unused_rpt = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;

    // Two-flop synchronizer for the asynchronous raw buttons.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 4'b0000;
            r_sync2 <= 4'b0000;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ch
        state_t           r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
        logic             r_release;
        logic             w_sync;
        logic             w_cnt_done;

        assign w_sync     = r_sync2[g];
        assign w_cnt_done = (r_cnt == CNT_LAST);

`ifdef BTN_DEB_REPEAT_EN
        logic [RPT_W-1:0] r_rpt;
        logic             r_rpt_phase;
        logic             w_release_now;
        logic             w_rpt_done;

        assign w_release_now = (r_state == S_DOWN_CHK) && !w_sync && w_cnt_done;
        // Phase 0 waits out the initial delay, phase 1 runs the repeat period.
        assign w_rpt_done    = (r_rpt == (r_rpt_phase ? RPT_PER_LAST : RPT_DLY_LAST));
`endif

        // Debounce FSM with registered level and pulse outputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= S_UP;
                r_cnt       <= '0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
`ifdef BTN_DEB_REPEAT_EN
                r_rpt       <= '0;
                r_rpt_phase <= 1'b0;
`endif
            end else begin
                r_press   <= 1'b0;
                r_release <= 1'b0;
                case (r_state)
                    S_UP: begin
                        if (w_sync) begin
                            r_state <= S_UP_CHK;
                            r_cnt   <= '0;
                        end
                    end
                    S_UP_CHK: begin
                        if (!w_sync) begin
                            r_state <= S_UP;
                        end else if (w_cnt_done) begin
                            r_state <= S_DOWN;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_DOWN: begin
                        if (!w_sync) begin
                            r_state <= S_DOWN_CHK;
                            r_cnt   <= '0;
                        end
                    end
                    S_DOWN_CHK: begin
                        if (w_sync) begin
                            r_state <= S_DOWN;
                        end else if (w_cnt_done) begin
                            r_state   <= S_UP;
                            r_level   <= 1'b0;
                            r_release <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_UP;
                        r_cnt   <= '0;
                        r_level <= 1'b0;
                    end
                endcase
`ifdef BTN_DEB_REPEAT_EN
                // Repeat timer runs only while held; an accepted release wins over a repeat.
                if (r_state == S_UP_CHK) begin
                    r_rpt       <= '0;
                    r_rpt_phase <= 1'b0;
                end else if ((r_state == S_DOWN) || (r_state == S_DOWN_CHK)) begin
                    if (w_release_now) begin
                        r_rpt       <= '0;
                        r_rpt_phase <= 1'b0;
                    end else if (w_rpt_done) begin
                        r_press     <= 1'b1;
                        r_rpt       <= '0;
                        r_rpt_phase <= 1'b1;
                    end else begin
                        r_rpt <= r_rpt + 1'b1;
                    end
                end
`endif
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce with short debounce and repeat timings.
// A run-length model predicts outputs every cycle; directed scenarios pin
// latencies and pulse patterns with hand-computed literals.
module tb_btn_debounce;

    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 6;

`ifdef BTN_DEB_REPEAT_EN
    localparam int EXP_RPT_CNT = 6;
    localparam int EXP_RPT_SUM = 210;
`else
    localparam int EXP_RPT_CNT = 0;
    localparam int EXP_RPT_SUM = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int errors = 0;
    int checks = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(4),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an input value is accepted once it has been seen on DEB+1
    // consecutive sampling edges, two edges after it is sampled from btn_raw.
    logic [3:0] e_level, e_press, e_release;
    logic [3:0] m_d1, m_d2;
    int         m_run  [4];
    int         m_hold [4];

    always @(posedge clk or negedge rst_n) begin
        logic [3:0] lv, pr, rl;
        int         rn [4];
        int         hd [4];
        if (!rst_n) begin
            e_level   <= 4'b0;
            e_press   <= 4'b0;
            e_release <= 4'b0;
            m_d1      <= 4'b0;
            m_d2      <= 4'b0;
            for (int c = 0; c < 4; c++) begin
                m_run[c]  <= 0;
                m_hold[c] <= 0;
            end
        end else begin
            lv = e_level;
            pr = 4'b0;
            rl = 4'b0;
            for (int c = 0; c < 4; c++) begin
                rn[c] = m_run[c];
                hd[c] = m_hold[c];
                if (m_d2[c] != lv[c]) rn[c] = rn[c] + 1;
                else rn[c] = 0;
                if (rn[c] == DEB + 1) begin
                    rn[c] = 0;
                    lv[c] = ~lv[c];
                    if (lv[c]) begin
                        pr[c] = 1'b1;
                        hd[c] = 0;
                    end else begin
                        rl[c] = 1'b1;
                    end
                end else if (lv[c]) begin
`ifdef BTN_DEB_REPEAT_EN
                    hd[c] = hd[c] + 1;
                    if (hd[c] == RD || (hd[c] > RD && ((hd[c] - RD) % RP) == 0))
                        pr[c] = 1'b1;
`endif
                end
                m_run[c]  <= rn[c];
                m_hold[c] <= hd[c];
            end
            e_level   <= lv;
            e_press   <= pr;
            e_release <= rl;
            m_d2      <= m_d1;
            m_d1      <= btn_raw;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_level", int'(btn_level), int'(e_level));
        chk("model_press", int'(btn_press), int'(e_press));
        chk("model_release", int'(btn_release), int'(e_release));
    end

    // Returns the index (0 = first edge after call) of the edge after which
    // the selected pulse vector equals vec, or -1 if not seen within max edges.
    task automatic wait_pulse(input bit rel, input logic [3:0] vec, input int max, output int k);
        k = -1;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            if ((rel ? btn_release : btn_press) == vec) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int quiet;
        int rcnt, rsum, rfirst;
        int rel_seen, prs_seen;

        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        repeat (3) @(negedge clk);
        chk("reset_level", int'(btn_level), 0);
        chk("reset_pulses", int'({btn_press, btn_release}), 0);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press and release on bit 0.
        btn_raw = 4'b0001;
        wait_pulse(1'b0, 4'b0001, 30, k);
        chk("press0_latency", k, 10);
        chk("press0_level", int'(btn_level), 1);
        @(posedge clk);
        #1;
        chk("press0_one_cycle", int'(btn_press), 0);
        repeat (28) @(posedge clk);
        @(negedge clk);
        btn_raw = 4'b0000;
        wait_pulse(1'b1, 4'b0001, 30, k);
        chk("release0_latency", k, 10);
        chk("release0_level", int'(btn_level), 0);
        @(posedge clk);
        #1;
        chk("release0_one_cycle", int'(btn_release), 0);
        repeat (4) @(negedge clk);

        // Bounce on bit 2, then held high.
        quiet = 1;
        btn_raw = 4'b0100; repeat (3) @(negedge clk) if (btn_level[2] | btn_press[2]) quiet = 0;
        btn_raw = 4'b0000; repeat (2) @(negedge clk) if (btn_level[2] | btn_press[2]) quiet = 0;
        btn_raw = 4'b0100; repeat (5) @(negedge clk) if (btn_level[2] | btn_press[2]) quiet = 0;
        btn_raw = 4'b0000; repeat (1) @(negedge clk) if (btn_level[2] | btn_press[2]) quiet = 0;
        chk("bounce_quiet", quiet, 1);
        btn_raw = 4'b0100;
        wait_pulse(1'b0, 4'b0100, 30, k);
        chk("bounce_press_latency", k, 10);
        @(negedge clk);
        btn_raw = 4'b0000;
        wait_pulse(1'b1, 4'b0100, 30, k);
        chk("bounce_release_latency", k, 10);
        repeat (4) @(negedge clk);

        // Bits 1 and 3 together.
        btn_raw = 4'b1010;
        wait_pulse(1'b0, 4'b1010, 30, k);
        chk("dual_press_latency", k, 10);
        chk("dual_level", int'(btn_level), 10);
        @(negedge clk);
        btn_raw = 4'b0000;
        wait_pulse(1'b1, 4'b1010, 30, k);
        chk("dual_release_latency", k, 10);
        repeat (4) @(negedge clk);

        // Reset in the middle of an UP_CHK on bit 0 while the button is held.
        btn_raw = 4'b0001;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("midreset_outputs", int'({btn_level, btn_press, btn_release}), 0);
        end
        #2 rst_n = 1'b1;
        wait_pulse(1'b0, 4'b0001, 30, k);
        chk("postreset_press_latency", k, 10);

        // Hold for 50 cycles after acceptance and record repeat pulses.
        rcnt = 0; rsum = 0; rfirst = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (btn_press[0]) begin
                rcnt++;
                rsum += i;
                if (rfirst == 0) rfirst = i;
            end
        end
        chk("repeat_count", rcnt, EXP_RPT_CNT);
        chk("repeat_offset_sum", rsum, EXP_RPT_SUM);
`ifdef BTN_DEB_REPEAT_EN
        chk("repeat_first_offset", rfirst, 20);
`endif

        // One-cycle low glitch during the hold.
        @(negedge clk);
        btn_raw = 4'b0000;
        @(negedge clk);
        btn_raw = 4'b0001;
        rel_seen = 0; prs_seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (btn_release[0]) rel_seen++;
            if (btn_press[0]) prs_seen++;
        end
        chk("glitch_no_release", rel_seen, 0);
`ifndef BTN_DEB_REPEAT_EN
        chk("glitch_no_press", prs_seen, 0);
`endif
        chk("glitch_level_held", int'(btn_level), 1);
        btn_raw = 4'b0000;
        wait_pulse(1'b1, 4'b0001, 30, k);
        chk("final_release_latency", k, 10);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
